// File: rtl/fft_mag_buffer.sv
// Streaming FFT magnitude capture: alpha-max-beta-min magnitude per bin, first
// STORE_BINS bins of an aligned frame stored and frozen for random reads.
`timescale 1ns/1ps
module fft_mag_buffer #(
  parameter int NFFT       = 1024,
  parameter int STORE_BINS = 512,
  parameter int ADDR_W     = 10,
  parameter int IN_W       = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fft_tvalid,
  input  logic [2*IN_W-1:0]   fft_tdata,
  input  logic                fft_tlast,
  output logic                fft_tready,
  input  logic [ADDR_W-1:0]   bram_addr,
  output logic [15:0]         data,
  output logic                ready,
  input  logic                done,
  output logic [7:0]          frame_count,
  output logic                frame_err
);

  localparam int IDX_W  = $clog2(NFFT);
  localparam int SIDX_W = (STORE_BINS > 1) ? $clog2(STORE_BINS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFFT - 1);

  typedef enum logic [1:0] {SYNC, FILL, DRAIN, HOLD} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic [7:0]       fc_q, fc_d;
  logic             accept, tag_v, tag_last, tag_w;

  logic [IN_W-1:0]   a1_q, b1_q, mx2_q, mn2_q;
  logic [SIDX_W-1:0] i1_q, i2_q, i3_q;
  logic              w1_q, w2_q, w3_q, l1_q, l2_q, l3_q;
  logic [15:0]       mag_d, mag3_q;

  logic [15:0]       mem [0:STORE_BINS-1];
  logic [ADDR_W-1:0] rd_addr_q;
  logic [15:0]       data_q;

  // Negating the most negative value wraps back to itself, so saturate it.
  function automatic logic [IN_W-1:0] sat_abs(input logic [IN_W-1:0] v);
    logic [IN_W-1:0] neg;
    neg = -v;
    if (!v[IN_W-1])
      return v;
    else if (neg[IN_W-1])
      return {1'b0, {(IN_W-1){1'b1}}};
    else
      return neg;
  endfunction

  assign accept     = fft_tvalid & reset;
  assign fft_tready = reset;
  assign tag_w      = tag_v && ({1'b0, idx_q} < (IDX_W+1)'(STORE_BINS));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    fc_d     = fc_q;
    tag_v    = 1'b0;
    tag_last = 1'b0;
    case (state_q)
      SYNC: begin
        if (accept && fft_tlast) begin
          state_d = FILL;
          idx_d   = '0;
        end
      end
      FILL: begin
        if (accept) begin
          tag_v = 1'b1;
          idx_d = idx_q + 1'b1;
          if (fft_tlast) begin
            idx_d = '0;
            if (idx_q == LAST_IDX) begin
              tag_last = 1'b1;
              state_d  = DRAIN;
            end else begin
              err_d = 1'b1;
            end
          end else if (idx_q == LAST_IDX) begin
            err_d   = 1'b1;
            state_d = SYNC;
          end
        end
      end
      // Publish on the edge that writes the final tagged bin.
      DRAIN: begin
        if (l3_q) begin
          state_d = HOLD;
          fc_d    = fc_q + 8'd1;
        end
      end
      HOLD: begin
        if (done) state_d = SYNC;
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= SYNC;
      idx_q   <= '0;
      err_q   <= 1'b0;
      fc_q    <= '0;
      w1_q    <= 1'b0;
      w2_q    <= 1'b0;
      w3_q    <= 1'b0;
      l1_q    <= 1'b0;
      l2_q    <= 1'b0;
      l3_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      fc_q    <= fc_d;
      w1_q    <= tag_w;
      w2_q    <= w1_q;
      w3_q    <= w2_q;
      l1_q    <= tag_last;
      l2_q    <= l1_q;
      l3_q    <= l2_q;
    end
  end

  assign mag_d = 16'(mx2_q) + 16'(mn2_q >> 2) + 16'(mn2_q >> 3);

  always_ff @(posedge clock) begin
    a1_q   <= sat_abs(fft_tdata[IN_W-1:0]);
    b1_q   <= sat_abs(fft_tdata[2*IN_W-1:IN_W]);
    i1_q   <= idx_q[SIDX_W-1:0];
    mx2_q  <= (a1_q >= b1_q) ? a1_q : b1_q;
    mn2_q  <= (a1_q >= b1_q) ? b1_q : a1_q;
    i2_q   <= i1_q;
    mag3_q <= mag_d;
    i3_q   <= i2_q;
  end

  always_ff @(posedge clock) begin
    if (w3_q && reset) mem[i3_q] <= mag3_q;
  end

  always_ff @(posedge clock) begin
    rd_addr_q <= bram_addr;
    if (!reset)
      data_q <= '0;
    else if ({1'b0, rd_addr_q} < (ADDR_W+1)'(STORE_BINS))
      data_q <= mem[rd_addr_q[SIDX_W-1:0]];
    else
      data_q <= '0;
  end

  assign data        = data_q;
  assign ready       = (state_q == HOLD);
  assign frame_count = fc_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_fft_mag_buffer.sv
// Scoreboard bench for fft_mag_buffer: random frames, arithmetic reference
// magnitude, reads checked by a decoupled monitor.
`timescale 1ns/1ps
module tb_fft_mag_buffer;
  localparam int NFFT = 1024;
  localparam int SB   = 512;
  localparam int AW   = 10;
  localparam int IW   = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          fft_tvalid = 1'b0;
  logic [2*IW-1:0] fft_tdata = '0;
  logic          fft_tlast = 1'b0;
  logic          fft_tready;
  logic [AW-1:0] bram_addr = '0;
  logic [15:0]   data;
  logic          ready;
  logic          done = 1'b0;
  logic [7:0]    frame_count;
  logic          frame_err;

  fft_mag_buffer #(.NFFT(NFFT), .STORE_BINS(SB), .ADDR_W(AW), .IN_W(IW)) dut (
    .clock(clock), .reset(reset), .fft_tvalid(fft_tvalid), .fft_tdata(fft_tdata),
    .fft_tlast(fft_tlast), .fft_tready(fft_tready), .bram_addr(bram_addr),
    .data(data), .ready(ready), .done(done), .frame_count(frame_count),
    .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int adr_q[$];
  logic rd_req = 1'b0, rd_d1 = 1'b0, rd_d2 = 1'b0;
  int re_a[NFFT];
  int im_a[NFFT];
  int exp_buf[SB];
  int exp_fc = 0;

  function automatic int ref_mag(input int re, input int im);
    int a, b, mx, mn;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    if (a > 32767) a = 32767;
    if (b > 32767) b = 32767;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return mx + mn / 4 + mn / 8;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clock) begin
    rd_d1 <= rd_req;
    rd_d2 <= rd_d1;
  end

  always @(negedge clock) begin
    if (rd_d2) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_underflow: read data %0d with no expected entry", data);
      end else begin
        int e, a;
        e = exp_q.pop_front();
        a = adr_q.pop_front();
        chk($sformatf("rd[%0d]", a), 32'(data), e);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input int re, input int im, input logic last, input logic dn);
    fft_tvalid = 1'b1;
    fft_tdata  = {im[15:0], re[15:0]};
    fft_tlast  = last;
    done       = dn;
    tick();
    fft_tvalid = 1'b0;
    fft_tlast  = 1'b0;
    done       = 1'b0;
  endtask

  task automatic send_frame(input int nb, input int last_at, input bit gaps, input bit done_on_last);
    for (int k = 0; k < nb; k++) begin
      if (gaps)
        for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++) tick();
      beat(re_a[k], im_a[k], k == last_at, done_on_last && (k == last_at));
    end
  endtask

  task automatic sync_beat();
    beat(0, 0, 1'b1, 1'b0);
  endtask

  task automatic set_ramp();
    for (int k = 0; k < NFFT; k++) begin
      re_a[k] = k;
      im_a[k] = 0;
    end
  endtask

  task automatic set_random();
    for (int k = 0; k < NFFT; k++) begin
      re_a[k] = int'($urandom_range(0, 65535)) - 32768;
      im_a[k] = int'($urandom_range(0, 65535)) - 32768;
    end
  endtask

  task automatic commit();
    for (int k = 0; k < SB; k++) exp_buf[k] = ref_mag(re_a[k], im_a[k]);
  endtask

  task automatic wait_publish(input string nm);
    int k;
    k = 1;
    while (ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk({nm, "_ready_latency"}, k, 4);
    exp_fc = (exp_fc + 1) % 256;
    chk({nm, "_frame_count"}, frame_count, exp_fc);
  endtask

  task automatic rd_lit(input int a, input int v);
    bram_addr = a[AW-1:0];
    rd_req    = 1'b1;
    exp_q.push_back(v);
    adr_q.push_back(a);
    tick();
  endtask

  task automatic rd_rand(input int n);
    for (int i = 0; i < n; i++) begin
      int a;
      a = int'($urandom_range(0, SB - 1));
      rd_lit(a, exp_buf[a]);
    end
  endtask

  task automatic rd_end();
    rd_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("ready_after_done", ready, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_ready", ready, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_data", data, 0);
    chk("rst_tready", fft_tready, 0);
    reset = 1'b1;
    tick();
    chk("tready_run", fft_tready, 1);

    // Ramp frame
    set_ramp();
    sync_beat();
    send_frame(NFFT, NFFT - 1, 1'b0, 1'b0);
    commit();
    wait_publish("ramp");
    rd_lit(5, 5);
    rd_lit(511, 511);
    rd_rand(16);
    rd_end();
    pulse_done();

    // Corner-value frame
    set_random();
    re_a[0] = 1000;   im_a[0] = 1000;
    re_a[1] = -32768; im_a[1] = 0;
    re_a[2] = 32767;  im_a[2] = 32767;
    re_a[3] = 3;      im_a[3] = -4;
    sync_beat();
    send_frame(NFFT, NFFT - 1, 1'b0, 1'b0);
    commit();
    wait_publish("corner");
    rd_lit(0, 1375);
    rd_lit(1, 32767);
    rd_lit(2, 45053);
    rd_lit(3, 4);
    rd_rand(16);
    rd_end();
    pulse_done();

    // Ramp again with random valid gaps
    set_ramp();
    sync_beat();
    send_frame(NFFT, NFFT - 1, 1'b1, 1'b0);
    commit();
    wait_publish("gappy");
    rd_lit(5, 5);
    rd_lit(511, 511);
    rd_rand(32);
    rd_end();

    // Frames streamed while frozen must not disturb the buffer
    set_random();
    send_frame(NFFT, NFFT - 1, 1'b0, 1'b0);
    chk("hold_ready", ready, 1);
    rd_rand(16);
    rd_end();
    set_random();
    send_frame(NFFT, NFFT - 1, 1'b0, 1'b1);
    chk("done_with_tlast_ready", ready, 0);
    chk("hold_fc", frame_count, exp_fc);
    set_random();
    send_frame(NFFT, NFFT - 1, 1'b0, 1'b0);
    repeat (8) tick();
    chk("resync_no_publish", ready, 0);
    set_random();
    send_frame(NFFT, NFFT - 1, 1'b0, 1'b0);
    commit();
    wait_publish("after_done");
    rd_rand(16);
    rd_end();
    pulse_done();

    // Early tlast
    sync_beat();
    set_random();
    send_frame(701, 700, 1'b0, 1'b0);
    repeat (6) tick();
    chk("early_tlast_err", frame_err, 1);
    chk("early_tlast_no_ready", ready, 0);
    set_random();
    send_frame(NFFT, NFFT - 1, 1'b0, 1'b0);
    commit();
    wait_publish("post_err");
    chk("err_sticky", frame_err, 1);
    rd_rand(16);
    rd_end();
    pulse_done();

    // Reset mid-FILL
    sync_beat();
    set_random();
    send_frame(300, -1, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk("rstfill_tready", fft_tready, 0);
    reset = 1'b1;
    chk("rstfill_fc", frame_count, 0);
    chk("rstfill_err", frame_err, 0);
    chk("rstfill_ready", ready, 0);
    exp_fc = 0;
    set_random();
    send_frame(NFFT, NFFT - 1, 1'b0, 1'b0);
    repeat (8) tick();
    chk("rstfill_sync_no_publish", ready, 0);
    set_random();
    send_frame(NFFT, NFFT - 1, 1'b0, 1'b0);
    commit();
    wait_publish("post_rst");
    chk("post_rst_err", frame_err, 0);
    rd_rand(16);
    rd_end();

    // Reset during HOLD
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rsthold_ready", ready, 0);
    chk("rsthold_fc", frame_count, 0);
    exp_fc = 0;

    // Missing tlast
    sync_beat();
    set_random();
    send_frame(NFFT, -1, 1'b0, 1'b0);
    repeat (6) tick();
    chk("missing_tlast_err", frame_err, 1);
    chk("missing_tlast_no_ready", ready, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
